button_pulser: RTL and testbench
================================

BUTTON_PULSER -- requirements
Module: button_pulser

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16'd50000, number of consecutive stable synchronized samples required to accept a press or a release; legal range 1..65535.
REQ-002 Parameter PULSE_CYCLES, default 16'd4, width in clk cycles of each pclk pulse; legal range 1..65535.
REQ-003 clk  input  1  board clock; sole clock of the block; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 uclk  input  1  raw, bouncy, asynchronous user push-button, active-high.
REQ-006 pclk  output  1  debounced pulse that clocks the Simon game core downstream; driven directly from a flop.
REQ-007 busy  output  1  high whenever the FSM is not in IDLE.
REQ-008 press_count  output  8  count of accepted presses, for debug display.

Function
REQ-009 uclk SHALL pass through a two-flop synchronizer (s1, s2); only s2 SHALL be used by the FSM.
REQ-010 FSM states SHALL be IDLE, ARMING, PULSE, HOLD and RELEASE, with one shared 16-bit counter cnt.
REQ-011 IDLE: s2=1 -> ARMING with cnt=1; otherwise remain in IDLE.
REQ-012 ARMING: s2=0 -> IDLE (bounce rejected, no pulse); s2=1 and cnt==DEBOUNCE_CYCLES -> PULSE with cnt=1; otherwise cnt+1.
REQ-013 PULSE: cnt==PULSE_CYCLES -> HOLD; otherwise cnt+1; s2 SHALL be ignored in PULSE.
REQ-014 HOLD: s2=0 -> RELEASE with cnt=1; otherwise remain in HOLD, so a held button yields exactly one pulse.
REQ-015 RELEASE: s2=1 -> HOLD (release bounce); s2=0 and cnt==DEBOUNCE_CYCLES -> IDLE; otherwise cnt+1.
REQ-016 pclk SHALL be 1 exactly while the registered state is PULSE, giving a high time of exactly PULSE_CYCLES clk cycles.
REQ-017 Latency: if uclk=1 is first sampled at edge N and stays high, pclk SHALL rise after edge N+DEBOUNCE_CYCLES+2.
REQ-018 press_count SHALL increment by 1 on each transition into PULSE and SHALL wrap from 255 to 0.
REQ-019 busy SHALL be registered-state decoded: 0 in IDLE, 1 in all other states.
REQ-020 A new pclk pulse SHALL NOT start until the FSM has passed through RELEASE and back to IDLE, which takes at least DEBOUNCE_CYCLES cycles of stable low.
REQ-021 cnt SHALL never exceed max(DEBOUNCE_CYCLES, PULSE_CYCLES), and no arithmetic overflow SHALL occur for any legal parameter value.

Reset
REQ-022 When rst=1 at a clk edge, the following SHALL be cleared on that edge: s1=0, s2=0, state=IDLE, cnt=0, pclk=0, busy=0 and press_count=0.
REQ-023 rst SHALL take priority over all FSM transitions.
REQ-024 rst asserted mid-PULSE SHALL drive pclk low after that edge, and press_count SHALL read 0 (the truncated pulse is not counted).
REQ-025 After rst deasserts with uclk held high, the press SHALL be re-qualified from IDLE with full REQ-017 latency.

Verification
Parameters for all scenarios: DEBOUNCE_CYCLES=4, PULSE_CYCLES=2.
REQ-026 Clean press: rst for 1 edge, then uclk=1 first sampled at edge 10 and held -> pclk=1 after edges 16 and 17 only, press_count=1, busy stays 1 while held.
REQ-027 Bounce reject: uclk high for 3 edges, low for 1, repeated 3 times -> pclk never rises, press_count=0, busy returns to 0.
REQ-028 Release bounce: after a pulse, uclk toggles 1-0-1-0 each edge, then stays low -> no second pulse; busy=0 four edges after s2 is last low-stable from 1.
REQ-029 Wrap: 256 clean press/release cycles -> press_count reads 0, and each pclk pulse is exactly 2 cycles wide.
REQ-030 Reset mid-pulse: rst=1 on the first pclk-high cycle -> pclk=0, busy=0 and press_count=0 after that edge; with uclk held, a new pulse occurs 6 edges after rst drops (REQ-017 latency of DEBOUNCE_CYCLES+2).

Source files
------------

// File: rtl/button_pulser.sv
// Debounces a raw push-button and emits one fixed-width pclk pulse per accepted press.
// A held button produces exactly one pulse; a new pulse needs a debounced release first.
module button_pulser #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [15:0] PULSE_CYCLES    = 16'd4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uclk,
   output logic       pclk,
   output logic       busy,
   output logic [7:0] press_count
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMING  = 3'd1,
      PULSE   = 3'd2,
      HOLD    = 3'd3,
      RELEASE = 3'd4
   } state_t;

   logic        s1_q, s2_q;
   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        pclk_q, pclk_d;
   logic [7:0]  count_q, count_d;

   // NOTE: every flop uses <= so all registers see pre-edge values, matching the hardware.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= 16'd0;
         pclk_q  <= 1'b0;
         count_q <= 8'd0;
      end else begin
         s1_q    <= uclk;
         s2_q    <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pclk_q  <= pclk_d;
         count_q <= count_d;
      end
   end

   // NOTE: defaults come first so every path assigns every output and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (s2_q) begin
               state_d = ARMING;
               cnt_d   = 16'd1;
            end
         end
         ARMING: begin
            if (!s2_q) begin
               state_d = IDLE;
            end else if (cnt_q == DEBOUNCE_CYCLES) begin
               state_d = PULSE;
               cnt_d   = 16'd1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         PULSE: begin
            if (cnt_q == PULSE_CYCLES) begin
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         HOLD: begin
            if (!s2_q) begin
               state_d = RELEASE;
               cnt_d   = 16'd1;
            end
         end
         RELEASE: begin
            if (s2_q) begin
               state_d = HOLD;
            end else if (cnt_q == DEBOUNCE_CYCLES) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 16'd0;
         end
      endcase
   end

   // pclk is a flop copy of "next state is PULSE", so it is high exactly while state_q is PULSE.
   always_comb begin
      pclk_d  = (state_d == PULSE);
      count_d = count_q;
      if (state_d == PULSE && state_q != PULSE) begin
         count_d = count_q + 8'd1;
      end
   end

   assign pclk        = pclk_q;
   assign busy        = (state_q != IDLE);
   assign press_count = count_q;

endmodule

// File: tb/tb_button_pulser.sv
// Self-checking bench for button_pulser: each expected pulse (rise edge, width, count)
// is queued when the press is driven and compared when the DUT's pulse ends.
module tb_button_pulser;

   localparam int D = 4;
   localparam int P = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       uclk;
   logic       pclk;
   logic       busy;
   logic [7:0] press_count;

   int n_compared   = 0;
   int n_mismatched = 0;
   int edge_n       = 0;

   typedef struct {
      int rise;
      int width;
      int count;
   } exp_t;

   exp_t sb[$];

   button_pulser #(
      .DEBOUNCE_CYCLES(16'd4),
      .PULSE_CYCLES   (16'd2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .uclk       (uclk),
      .pclk       (pclk),
      .busy       (busy),
      .press_count(press_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n++;

   task automatic check(input string tag, input int got, input int exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   task automatic push_exp(input int rise, input int width, input int count);
      exp_t e;
      e.rise  = rise;
      e.width = width;
      e.count = count;
      sb.push_back(e);
   endtask

   task automatic wait_negs(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Pulse monitor: samples 1 time unit after each rising edge.
   int   rise_at     = 0;
   int   cnt_at_rise = 0;
   logic pclk_prev   = 1'b0;

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (pclk === 1'b1 && pclk_prev === 1'b0) begin
         rise_at     = edge_n;
         cnt_at_rise = int'(press_count);
      end
      if (pclk === 1'b0 && pclk_prev === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", 1, 0);
         end else begin
            e = sb.pop_front();
            check("pulse_rise_edge", rise_at, e.rise);
            check("pulse_width", edge_n - rise_at, e.width);
            check("pulse_count", cnt_at_rise, e.count);
         end
      end
      pclk_prev = pclk;
   end

   initial begin
      int k;
      int exp_cnt;
      rst  = 1'b1;
      uclk = 1'b0;
      wait_negs(2);
      check("rst_pclk", int'(pclk), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_count", int'(press_count), 0);
      rst = 1'b0;

      // Clean press held, then released.
      do_reset();
      uclk = 1'b1;
      k = edge_n;
      push_exp(k + 1 + D + 2, P, 1);
      wait_negs(6);
      check("clean_pclk_before_latency", int'(pclk), 0);
      check("clean_busy_arming", int'(busy), 1);
      wait_negs(1);
      check("clean_pclk_hi1", int'(pclk), 1);
      wait_negs(1);
      check("clean_pclk_hi2", int'(pclk), 1);
      wait_negs(1);
      check("clean_pclk_lo", int'(pclk), 0);
      wait_negs(10);
      check("clean_busy_held", int'(busy), 1);
      check("clean_count", int'(press_count), 1);
      uclk = 1'b0;
      wait_negs(12);
      check("clean_busy_idle", int'(busy), 0);

      // Press bounce: 3 high, 1 low, three times.
      do_reset();
      repeat (3) begin
         uclk = 1'b1;
         wait_negs(3);
         uclk = 1'b0;
         wait_negs(1);
      end
      wait_negs(10);
      check("bounce_count", int'(press_count), 0);
      check("bounce_busy", int'(busy), 0);

      // Release bounce after one pulse.
      do_reset();
      uclk = 1'b1;
      push_exp(edge_n + 1 + D + 2, P, 1);
      wait_negs(14);
      uclk = 1'b0;
      wait_negs(1);
      uclk = 1'b1;
      wait_negs(1);
      uclk = 1'b0;
      wait_negs(1);
      uclk = 1'b1;
      wait_negs(1);
      uclk = 1'b0;
      k = edge_n;
      wait_negs(6);
      check("relbounce_busy_counting", int'(busy), 1);
      wait_negs(1);
      check("relbounce_busy_idle", int'(busy), 0);
      wait_negs(6);
      check("relbounce_count", int'(press_count), 1);

      // 256 clean presses wrap the counter back to 0.
      do_reset();
      exp_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         uclk = 1'b1;
         exp_cnt = (exp_cnt + 1) % 256;
         push_exp(edge_n + 1 + D + 2, P, exp_cnt);
         wait_negs(10);
         uclk = 1'b0;
         wait_negs(10);
      end
      check("wrap_count", int'(press_count), 0);
      check("wrap_busy", int'(busy), 0);

      // Reset on the first pclk-high cycle, button held throughout.
      do_reset();
      uclk = 1'b1;
      k = edge_n;
      push_exp(k + 1 + D + 2, 1, 1);
      wait_negs(1 + D + 2);
      check("midrst_pclk_before", int'(pclk), 1);
      rst = 1'b1;
      wait_negs(1);
      check("midrst_pclk", int'(pclk), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_count", int'(press_count), 0);
      rst = 1'b0;
      push_exp(edge_n + 1 + D + 2, P, 1);
      wait_negs(D + 2);
      check("midrst_pclk_not_yet", int'(pclk), 0);
      wait_negs(1);
      check("midrst_pclk_again", int'(pclk), 1);
      wait_negs(4);
      uclk = 1'b0;
      wait_negs(12);
      check("midrst_busy_end", int'(busy), 0);

      check("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
